// File: rtl/half_adder_df.sv
// ----------------------------------------------------------------------------
// half_adder_df
//   Half adder with a live dataflow path plus a registered, qualified copy
//   of the result and two statistics counters.
//
// Ports
//   clk         in   1      sole clock, rising edge
//   rst_n       in   1      asynchronous active-low reset
//   a, b        in   1      addend bits
//   in_valid    in   1      qualifies a/b for the registered path and counters
//   clr         in   1      synchronous clear of both counters
//   sum         out  1      combinational a ^ b
//   carry       out  1      combinational a & b
//   sum_q       out  1      registered sum of the last accepted sample
//   carry_q     out  1      registered carry of the last accepted sample
//   out_valid   out  1      in_valid delayed by one clock
//   sample_cnt  out  CNT_W  accepted samples, wrapping
//   carry_cnt   out  CNT_W  accepted samples with carry set, saturating
// ----------------------------------------------------------------------------
module half_adder_df #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  input  logic             clr,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Increment that sticks at all-ones instead of rolling over.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  logic             sum_s;
  logic             carry_s;
  logic             accept_s;

  logic             sum_hold_q,   sum_hold_d;
  logic             carry_hold_q, carry_hold_d;
  logic             valid_q,      valid_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] carry_cnt_q,  carry_cnt_d;

  // Pure dataflow path: independent of clock, reset and qualifiers.
  assign sum_s   = a ^ b;
  assign carry_s = a & b;
  assign sum     = sum_s;
  assign carry   = carry_s;

  // Reset is handled by the flops, so a live edge with in_valid high is an acceptance.
  assign accept_s = in_valid;

  // Next-state for the registered result, valid flag and counters.
  always_comb begin
    sum_hold_d   = sum_hold_q;
    carry_hold_d = carry_hold_q;
    sample_cnt_d = sample_cnt_q;
    carry_cnt_d  = carry_cnt_q;
    valid_d      = in_valid;

    if (accept_s) begin
      sum_hold_d   = sum_s;
      carry_hold_d = carry_s;
    end else begin
      sum_hold_d   = sum_hold_q;
      carry_hold_d = carry_hold_q;
    end

    // clr outranks a simultaneous acceptance for the counters only.
    if (clr) begin
      sample_cnt_d = CNT_ZERO;
      carry_cnt_d  = CNT_ZERO;
    end else if (accept_s) begin
      sample_cnt_d = sample_cnt_q + CNT_ONE;
      if (carry_s) begin
        carry_cnt_d = sat_inc(carry_cnt_q);
      end else begin
        carry_cnt_d = carry_cnt_q;
      end
    end else begin
      sample_cnt_d = sample_cnt_q;
      carry_cnt_d  = carry_cnt_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_hold_q   <= 1'b0;
      carry_hold_q <= 1'b0;
      valid_q      <= 1'b0;
      sample_cnt_q <= CNT_ZERO;
      carry_cnt_q  <= CNT_ZERO;
    end else begin
      sum_hold_q   <= sum_hold_d;
      carry_hold_q <= carry_hold_d;
      valid_q      <= valid_d;
      sample_cnt_q <= sample_cnt_d;
      carry_cnt_q  <= carry_cnt_d;
    end
  end

  assign sum_q      = sum_hold_q;
  assign carry_q    = carry_hold_q;
  assign out_valid  = valid_q;
  assign sample_cnt = sample_cnt_q;
  assign carry_cnt  = carry_cnt_q;

endmodule

// File: tb/tb_half_adder_df.sv
module tb_half_adder_df;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clk_run = 1'b0;
  logic         rst_n;
  logic         a, b, in_valid, clr;
  logic         sum, carry, sum_q, carry_q, out_valid;
  logic [W-1:0] sample_cnt, carry_cnt;

  int passes = 0;
  int total  = 0;

  // scoreboard state for the random phase
  logic         m_sum, m_carry, m_valid;
  logic [W-1:0] m_sc, m_cc;

  half_adder_df #(.CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .clr(clr),
    .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
    .out_valid(out_valid), .sample_cnt(sample_cnt), .carry_cnt(carry_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // advance one rising edge and sample 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a = 1'b0; b = 1'b0; in_valid = 1'b0; clr = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sum_q", {31'd0, sum_q}, 32'd0);
    chk("rst_carry_q", {31'd0, carry_q}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sample_cnt", {28'd0, sample_cnt}, 32'd0);
    chk("rst_carry_cnt", {28'd0, carry_cnt}, 32'd0);
    // dataflow stays live during reset
    a = 1'b1; b = 1'b1;
    #1;
    chk("rst_comb_sum", {31'd0, sum}, 32'd0);
    chk("rst_comb_carry", {31'd0, carry}, 32'd1);

    // truth table with the clock idle
    rst_n = 1'b1;
    a = 1'b0; b = 1'b0; #10;
    chk("tt00", {30'd0, carry, sum}, 32'd0);
    a = 1'b0; b = 1'b1; #10;
    chk("tt01", {30'd0, carry, sum}, 32'd1);
    a = 1'b1; b = 1'b0; #10;
    chk("tt10", {30'd0, carry, sum}, 32'd1);
    a = 1'b1; b = 1'b1; #10;
    chk("tt11", {30'd0, carry, sum}, 32'd2);

    // first acceptance after reset
    clk_run = 1'b1;
    in_valid = 1'b1; a = 1'b1; b = 1'b1;
    step();
    chk("acc11_sum_q", {31'd0, sum_q}, 32'd0);
    chk("acc11_carry_q", {31'd0, carry_q}, 32'd1);
    chk("acc11_out_valid", {31'd0, out_valid}, 32'd1);
    chk("acc11_sample_cnt", {28'd0, sample_cnt}, 32'd1);
    chk("acc11_carry_cnt", {28'd0, carry_cnt}, 32'd1);

    // idle cycle holds results
    in_valid = 1'b0; a = 1'b0; b = 1'b1;
    step();
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_sum_q", {31'd0, sum_q}, 32'd0);
    chk("idle_carry_q", {31'd0, carry_q}, 32'd1);
    chk("idle_sample_cnt", {28'd0, sample_cnt}, 32'd1);

    in_valid = 1'b1;
    step();
    chk("acc01_sum_q", {31'd0, sum_q}, 32'd1);
    chk("acc01_carry_q", {31'd0, carry_q}, 32'd0);
    chk("acc01_carry_cnt", {28'd0, carry_cnt}, 32'd1);

    // clear, then 20 carries: wrap and saturation
    in_valid = 1'b0; clr = 1'b1;
    step();
    chk("clr_sample_cnt", {28'd0, sample_cnt}, 32'd0);
    chk("clr_carry_cnt", {28'd0, carry_cnt}, 32'd0);
    clr = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1;
    for (int i = 0; i < 20; i++) step();
    chk("sat_carry_cnt", {28'd0, carry_cnt}, 32'd15);
    chk("wrap_sample_cnt", {28'd0, sample_cnt}, 32'd4);

    // clr together with acceptance
    clr = 1'b1; a = 1'b1; b = 1'b0;
    step();
    chk("clracc_sample_cnt", {28'd0, sample_cnt}, 32'd0);
    chk("clracc_carry_cnt", {28'd0, carry_cnt}, 32'd0);
    chk("clracc_sum_q", {31'd0, sum_q}, 32'd1);
    chk("clracc_carry_q", {31'd0, carry_q}, 32'd0);
    chk("clracc_out_valid", {31'd0, out_valid}, 32'd1);

    // five accepts, then reset between edges
    clr = 1'b0; a = 1'b1; b = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_sample_cnt", {28'd0, sample_cnt}, 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sum_q", {31'd0, sum_q}, 32'd0);
    chk("mid_rst_carry_q", {31'd0, carry_q}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_sample_cnt", {28'd0, sample_cnt}, 32'd0);
    chk("mid_rst_carry_cnt", {28'd0, carry_cnt}, 32'd0);
    a = 1'b0; b = 1'b1;
    #1;
    chk("mid_rst_comb", {30'd0, carry, sum}, 32'd1);
    rst_n = 1'b1;
    a = 1'b1; b = 1'b1; in_valid = 1'b1;
    step();
    chk("post_rst_sample_cnt", {28'd0, sample_cnt}, 32'd1);
    chk("post_rst_carry_cnt", {28'd0, carry_cnt}, 32'd1);

    // pseudo-random phase against a scoreboard
    m_sum = 1'b0; m_carry = 1'b1; m_valid = 1'b1; m_sc = 4'd1; m_cc = 4'd1;
    for (int i = 0; i < 1000; i++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 31) == 0);
      #1;
      chk("rnd_comb", {30'd0, carry, sum}, {31'd0, a} + {31'd0, b});
      m_valid = in_valid;
      if (in_valid) begin
        m_sum = (a != b);
        m_carry = a && b;
      end
      if (clr) begin
        m_sc = 4'd0; m_cc = 4'd0;
      end else if (in_valid) begin
        m_sc = m_sc + 4'd1;
        if (a && b && m_cc != 4'd15) m_cc = m_cc + 4'd1;
      end
      step();
      chk("rnd_regs", {29'd0, out_valid, carry_q, sum_q}, {29'd0, m_valid, m_carry, m_sum});
      chk("rnd_cnts", {24'd0, carry_cnt, sample_cnt}, {24'd0, m_cc, m_sc});
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/half_adder_df.md
HALF_ADDER_DF -- requirements
Module: half_adder_df

Interface
REQ-001 Parameter CNT_W, default 16: width of both statistics counters; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  1  addend bit A.
REQ-005 b  input  1  addend bit B.
REQ-006 in_valid  input  1  qualifies a/b for the registered path and the counters.
REQ-007 clr  input  1  synchronous clear of both counters.
REQ-008 sum  output  1  combinational a XOR b.
REQ-009 carry  output  1  combinational a AND b.
REQ-010 sum_q  output  1  registered sum of the last accepted sample.
REQ-011 carry_q  output  1  registered carry of the last accepted sample.
REQ-012 out_valid  output  1  registered copy of in_valid; marks sum_q/carry_q as fresh.
REQ-013 sample_cnt  output  CNT_W  count of accepted samples, wrapping.
REQ-014 carry_cnt  output  CNT_W  count of accepted samples with carry=1, saturating.

Function
REQ-015 sum and carry SHALL be pure dataflow of a and b: zero cycles of latency, no dependence on clk, rst_n, in_valid or clr.
REQ-016 sum and carry SHALL settle within the same simulation time step as any change on a or b, including while rst_n is low.
REQ-017 Truth table: a=0,b=0 gives sum 0, carry 0; a=0,b=1 gives 1,0; a=1,b=0 gives 1,0; a=1,b=1 gives 0,1.
REQ-018 A sample SHALL be accepted on a rising clk edge where rst_n=1 and in_valid=1.
REQ-019 On acceptance, sum_q and carry_q SHALL load (a XOR b) and (a AND b); otherwise they SHALL hold their value.
REQ-020 out_valid SHALL equal in_valid delayed by one clock (1-cycle latency), with no back-pressure and no ready signal.
REQ-021 On acceptance, sample_cnt SHALL increment by 1, wrapping from 2^CNT_W-1 to 0.
REQ-022 On acceptance with a=1 and b=1, carry_cnt SHALL increment by 1 and SHALL saturate at 2^CNT_W-1.
REQ-023 When clr=1 at a rising edge, both counters SHALL become 0; clr SHALL take priority over a simultaneous acceptance.
REQ-024 clr SHALL NOT affect sum_q, carry_q or out_valid; an acceptance in the same cycle as clr still updates them.
REQ-025 The arithmetic identity {carry, sum} = a + b (2-bit unsigned) SHALL hold at all times; the same identity SHALL hold for {carry_q, sum_q} against the accepted sample.

Reset
REQ-026 While rst_n=0, sum_q, carry_q, out_valid, sample_cnt and carry_cnt SHALL be 0, taking effect immediately and asynchronously to clk.
REQ-027 The first acceptance SHALL occur at the first rising edge after rst_n deasserts at which in_valid=1.
REQ-028 A reset asserted mid-operation SHALL discard any in-flight sample and clear all counts; the combinational sum and carry remain live.

Verification
REQ-029 clk held idle, rst_n=1; drive a,b = 00, 01, 10, 11, each held 10 time units -> sum/carry = 0/0, 1/0, 1/0, 0/1 after each step.
REQ-030 in_valid=1 with a=1,b=1 at edge N -> at edge N: sum_q=0, carry_q=1, out_valid=1; in_valid=0 at edge N+1 -> out_valid=0 with sum_q/carry_q held.
REQ-031 CNT_W=4, 20 accepted samples with a=b=1 -> carry_cnt stops at 15; sample_cnt reads 20 mod 16 = 4.
REQ-032 clr=1 and an accepted sample in the same cycle -> sample_cnt=0 and carry_cnt=0, while sum_q/carry_q/out_valid still update.
REQ-033 rst_n pulled low between edges after 5 accepted samples -> all registered outputs and counters read 0 immediately, before the next edge; sum/carry still track a,b.
REQ-034 Random a/b/in_valid for 1000 cycles -> {carry,sum}=a+b every step, and a scoreboard matches sample_cnt and carry_cnt.
